// File: rtl/clock_timekeeper_p.sv
// Centisecond timekeeper: divided tick, msec/sec/min/hour carry chain, run/hold,
// button time-set, 12/24-hour display mapping and an hh:mm alarm pulse.
`timescale 1ns/1ps

module clock_timekeeper_p #(
  parameter int CLK_DIV = 1_000_000,
  parameter int DIV_W   = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       btn_hour,
  input  logic       btn_min,
  input  logic       btn_sec,
  input  logic       mode_12h,
  input  logic       alarm_en,
  input  logic [4:0] alarm_hour,
  input  logic [5:0] alarm_min,
  output logic [6:0] o_msec,
  output logic [5:0] o_sec,
  output logic [5:0] o_min,
  output logic [4:0] o_hour,
  output logic       o_pm,
  output logic       o_alarm
);

  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q, div_next;
  logic [6:0]       msec_q, msec_next;
  logic [5:0]       sec_q, sec_next;
  logic [5:0]       min_q, min_next;
  logic [4:0]       hour_q, hour_next;
  logic             hour_prev_q, min_prev_q, sec_prev_q;
  logic             hour_edge_q, min_edge_q, sec_edge_q;
  logic             alarm_q;

  logic tick;
  logic msec_wrap;
  logic sec_wrap;
  logic min_carry;
  logic min_wrap;
  logic alarm_hit;

  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    // A pending seconds-sync edge swallows the tick of the same cycle.
    tick      = run && (div_q == DIV_MAX) && !sec_edge_q;
    msec_wrap = tick && (msec_q == 7'd99);
    sec_wrap  = msec_wrap && (sec_q == 6'd59);
    // The minute button owns the minute field this cycle; the carry is dropped.
    min_carry = sec_wrap && !min_edge_q;
    min_wrap  = min_carry && (min_q == 6'd59);

    div_next  = div_q;
    msec_next = msec_q;
    sec_next  = sec_q;
    min_next  = min_q;
    hour_next = hour_q;

    if (sec_edge_q) begin
      div_next  = '0;
      msec_next = '0;
      sec_next  = '0;
    end else if (run) begin
      div_next = (div_q == DIV_MAX) ? '0 : div_q + DIV_W'(1);
      if (tick) begin
        msec_next = msec_wrap ? 7'd0 : msec_q + 7'd1;
        if (msec_wrap)
          sec_next = sec_wrap ? 6'd0 : sec_q + 6'd1;
      end
    end

    if (min_edge_q || min_carry)
      min_next = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;

    if (hour_edge_q || min_wrap)
      hour_next = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;

    alarm_hit = min_carry && alarm_en &&
                (hour_next == alarm_hour) && (min_next == alarm_min);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q       <= '0;
      msec_q      <= '0;
      sec_q       <= '0;
      min_q       <= '0;
      hour_q      <= '0;
      hour_prev_q <= 1'b0;
      min_prev_q  <= 1'b0;
      sec_prev_q  <= 1'b0;
      hour_edge_q <= 1'b0;
      min_edge_q  <= 1'b0;
      sec_edge_q  <= 1'b0;
      alarm_q     <= 1'b0;
    end else begin
      div_q       <= div_next;
      msec_q      <= msec_next;
      sec_q       <= sec_next;
      min_q       <= min_next;
      hour_q      <= hour_next;
      hour_prev_q <= btn_hour;
      min_prev_q  <= btn_min;
      sec_prev_q  <= btn_sec;
      hour_edge_q <= btn_hour & ~hour_prev_q;
      min_edge_q  <= btn_min & ~min_prev_q;
      sec_edge_q  <= btn_sec & ~sec_prev_q;
      alarm_q     <= alarm_hit;
    end
  end

  // Display mapping only; the internal hour stays in 24-hour form.
  always_comb begin
    o_hour = hour_q;
    o_pm   = 1'b0;
    if (mode_12h) begin
      o_pm = (hour_q >= 5'd12);
      if (hour_q == 5'd0)
        o_hour = 5'd12;
      else if (hour_q > 5'd12)
        o_hour = hour_q - 5'd12;
    end
  end

  assign o_msec  = msec_q;
  assign o_sec   = sec_q;
  assign o_min   = min_q;
  assign o_alarm = alarm_q;

endmodule

// File: tb/tb_clock_timekeeper_p.sv
// Bench for clock_timekeeper_p: time-of-day model in total centiseconds, checked
// every cycle, plus directed scenarios with hand-computed literal expectations.
`timescale 1ns/1ps

module tb_clock_timekeeper_p;

  localparam int CLK_DIV = 4;
  localparam int DIV_W   = 3;
  localparam int DAY_CS  = 24 * 60 * 60 * 100;
  localparam int LIM     = 30000;

  logic       clk = 1'b0;
  logic       rst;
  logic       run, btn_hour, btn_min, btn_sec, mode_12h, alarm_en;
  logic [4:0] alarm_hour;
  logic [5:0] alarm_min;
  logic [6:0] o_msec;
  logic [5:0] o_sec, o_min;
  logic [4:0] o_hour;
  logic       o_pm, o_alarm;

  int tests  = 0;
  int failed = 0;
  int alarm_seen = 0;

  clock_timekeeper_p #(.CLK_DIV(CLK_DIV), .DIV_W(DIV_W)) dut (
    .clk(clk), .rst(rst), .run(run),
    .btn_hour(btn_hour), .btn_min(btn_min), .btn_sec(btn_sec),
    .mode_12h(mode_12h), .alarm_en(alarm_en),
    .alarm_hour(alarm_hour), .alarm_min(alarm_min),
    .o_msec(o_msec), .o_sec(o_sec), .o_min(o_min), .o_hour(o_hour),
    .o_pm(o_pm), .o_alarm(o_alarm)
  );

  always #5 clk = ~clk;

  // Model: time of day as one centisecond count, divider phase, button history.
  typedef struct packed {
    int phase;
    int cs;
    bit alarm;
    bit pv_h, pv_m, pv_s;
    bit ed_h, ed_m, ed_s;
  } model_t;

  model_t m;

  function automatic int f_h(int cs);  return cs / 360000;       endfunction
  function automatic int f_m(int cs);  return (cs / 6000) % 60;  endfunction
  function automatic int f_s(int cs);  return (cs / 100) % 60;   endfunction
  function automatic int f_ms(int cs); return cs % 100;          endfunction

  function automatic model_t next_model(model_t c, bit run_i, bit bh, bit bm,
                                        bit bs, bit aen, int ah, int am);
    model_t n;
    int h, mi, s, ms, h2, m2, s2, ms2, nx;
    bit tk;
    n  = c;
    h  = f_h(c.cs);  mi = f_m(c.cs);  s = f_s(c.cs);  ms = f_ms(c.cs);
    tk = run_i && (c.phase == CLK_DIV - 1);
    if (run_i) n.phase = (c.phase + 1) % CLK_DIV;
    h2 = h;  m2 = mi;  s2 = s;  ms2 = ms;
    if (c.ed_s) begin
      n.phase = 0;  s2 = 0;  ms2 = 0;  tk = 1'b0;
    end else if (tk) begin
      nx = (c.cs + 1) % DAY_CS;
      h2 = f_h(nx);  m2 = f_m(nx);  s2 = f_s(nx);  ms2 = f_ms(nx);
    end
    if (c.ed_m) begin
      m2 = (mi + 1) % 60;
      h2 = h;
    end
    if (c.ed_h) h2 = (h + 1) % 24;
    n.alarm = tk && !c.ed_m && (s == 59) && (ms == 99) && aen &&
              (h2 == ah) && (m2 == am);
    n.cs   = ((h2 * 60 + m2) * 60 + s2) * 100 + ms2;
    n.ed_h = bh && !c.pv_h;  n.pv_h = bh;
    n.ed_m = bm && !c.pv_m;  n.pv_m = bm;
    n.ed_s = bs && !c.pv_s;  n.pv_s = bs;
    return n;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) m <= '0;
    else      m <= next_model(m, run, btn_hour, btn_min, btn_sec, alarm_en,
                              int'(alarm_hour), int'(alarm_min));
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Per-cycle compare against the model, well clear of both clock edges.
  always @(negedge clk) begin
    int h, eh, epm;
    #3;
    h   = f_h(m.cs);
    eh  = mode_12h ? ((h % 12 == 0) ? 12 : h % 12) : h;
    epm = (mode_12h && h >= 12) ? 1 : 0;
    if (o_alarm === 1'b1) alarm_seen++;
    tests++;
    if (o_hour !== 5'(eh) || o_pm !== 1'(epm) || o_min !== 6'(f_m(m.cs)) ||
        o_sec !== 6'(f_s(m.cs)) || o_msec !== 7'(f_ms(m.cs)) || o_alarm !== m.alarm) begin
      failed++;
      $display("FAIL cycle @%0t: got %0d:%0d:%0d.%0d pm=%0d al=%0d, expected %0d:%0d:%0d.%0d pm=%0d al=%0d",
               $time, o_hour, o_min, o_sec, o_msec, o_pm, o_alarm,
               eh, f_m(m.cs), f_s(m.cs), f_ms(m.cs), epm, m.alarm);
    end
  end

  task automatic press(input int which, input int times);
    for (int i = 0; i < times; i++) begin
      @(negedge clk);
      case (which)
        0: btn_hour = 1'b1;
        1: btn_min  = 1'b1;
        default: btn_sec = 1'b1;
      endcase
      @(negedge clk);
      btn_hour = 1'b0;  btn_min = 1'b0;  btn_sec = 1'b0;
    end
    @(negedge clk);
  endtask

  initial begin
    int n;
    rst = 1'b0;  run = 1'b1;  btn_hour = 1'b0;  btn_min = 1'b0;  btn_sec = 1'b0;
    mode_12h = 1'b0;  alarm_en = 1'b0;  alarm_hour = '0;  alarm_min = '0;

    repeat (3) @(negedge clk);
    #1;
    check("reset_time", {o_hour, o_min, o_sec, o_msec}, 32'd0);
    check("reset_flags", {o_pm, o_alarm}, 32'd0);

    // Divider latency and first second.
    @(negedge clk);  rst = 1'b1;
    repeat (4) @(negedge clk);
    #1 check("first_msec", o_msec, 32'd1);
    repeat (392) @(negedge clk);
    #1 check("msec_99", o_msec, 32'd99);
    repeat (4) @(negedge clk);
    #1 check("sec_carry", {o_sec, o_msec}, {6'd1, 7'd0});

    // Hold with the divider two counts in, then resume.
    repeat (2) @(negedge clk);
    run = 1'b0;
    repeat (50) @(negedge clk);
    #1 check("hold_frozen", {o_sec, o_msec}, {6'd1, 7'd0});
    run = 1'b1;
    @(negedge clk);
    #1 check("resume_partial", o_msec, 32'd0);
    @(negedge clk);
    #1 check("resume_step", o_msec, 32'd1);

    // Display mapping at hours 0, 12, 13, 23.
    @(negedge clk);
    mode_12h = 1'b1;  #1 check("h0_12h", {o_hour, o_pm}, {5'd12, 1'b0});
    mode_12h = 1'b0;  #1 check("h0_24h", {o_hour, o_pm}, {5'd0, 1'b0});
    press(0, 12);
    mode_12h = 1'b1;  #1 check("h12_12h", {o_hour, o_pm}, {5'd12, 1'b1});
    mode_12h = 1'b0;  #1 check("h12_24h", {o_hour, o_pm}, {5'd12, 1'b0});
    press(0, 1);
    mode_12h = 1'b1;  #1 check("h13_12h", {o_hour, o_pm}, {5'd1, 1'b1});
    mode_12h = 1'b0;  #1 check("h13_24h", {o_hour, o_pm}, {5'd13, 1'b0});
    press(0, 10);
    mode_12h = 1'b1;  #1 check("h23_12h", {o_hour, o_pm}, {5'd11, 1'b1});
    mode_12h = 1'b0;  #1 check("h23_24h", {o_hour, o_pm}, {5'd23, 1'b0});

    // Set 23:59, sync seconds, roll over midnight with a disabled 00:00 alarm.
    press(1, 59);
    press(2, 1);
    #1 check("set_2359", {o_hour, o_min, o_sec, o_msec}, {5'd23, 6'd59, 6'd0, 7'd0});
    n = 0;
    while (m.cs != 0 && n < LIM) begin @(negedge clk); n++; end
    check("wait_midnight", n < LIM, 1);
    #1 check("midnight", {o_hour, o_min, o_sec, o_msec, o_alarm}, 32'd0);

    // Enabled alarm at 00:01 fires for one clock on the tick-driven carry.
    alarm_en = 1'b1;  alarm_hour = 5'd0;  alarm_min = 6'd1;
    n = 0;
    while (m.cs != 6000 && n < LIM) begin @(negedge clk); n++; end
    check("wait_0001", n < LIM, 1);
    #1 check("alarm_fire", {o_min, o_sec, o_alarm}, {6'd1, 6'd0, 1'b1});
    @(negedge clk);
    #1 check("alarm_one_clk", o_alarm, 32'd0);

    // Reaching the alarm minute by button must stay silent.
    alarm_min = 6'd5;
    press(1, 9);
    #1 check("btn_min_10", o_min, 32'd10);

    // Minute button edge coincident with the sec 59->0 carry.
    n = 0;
    while (!(f_s(m.cs) == 59 && f_ms(m.cs) == 99 && m.phase == CLK_DIV - 2) && n < LIM) begin
      @(negedge clk); n++;
    end
    check("wait_5999", n < LIM, 1);
    btn_min = 1'b1;
    @(negedge clk);  btn_min = 1'b0;
    @(negedge clk);
    #1 check("min_edge_vs_carry", {o_hour, o_min, o_sec, o_msec}, {5'd0, 6'd11, 6'd0, 7'd0});

    // Seconds sync coincident with a tick at msec 5: tick lost, divider restarts.
    n = 0;
    while (!(f_ms(m.cs) == 5 && m.phase == CLK_DIV - 2) && n < LIM) begin
      @(negedge clk); n++;
    end
    check("wait_ms5", n < LIM, 1);
    btn_sec = 1'b1;
    @(negedge clk);  btn_sec = 1'b0;
    @(negedge clk);
    #1 check("sec_sync_vs_tick", {o_sec, o_msec}, 32'd0);
    repeat (3) @(negedge clk);
    #1 check("sync_div_restart", o_msec, 32'd0);
    @(negedge clk);
    #1 check("sync_first_tick", o_msec, 32'd1);

    // Asynchronous reset mid-count.
    repeat (37) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1 check("async_reset", {o_hour, o_min, o_sec, o_msec, o_pm, o_alarm}, 32'd0);
    mode_12h = 1'b1;
    #1 check("reset_12h", {o_hour, o_pm}, {5'd12, 1'b0});
    repeat (2) @(negedge clk);
    rst = 1'b1;  mode_12h = 1'b0;
    repeat (5) @(negedge clk);

    check("alarm_pulses", alarm_seen, 32'd1);
    #4;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/clock_timekeeper_p.md
Name: clock_timekeeper_p

Overview:
- Parametrised successor of the stopwatch/clock datapath.
- Divides the system clock down to a centisecond tick and keeps time in a msec(0-99)/sec/min/hour carry chain.
- Adds run/hold, 12/24-hour display mode with PM flag, button time-set, and an hh:mm alarm pulse.
- Sits under the top-level clock wrapper; feeds the FND display mux directly.

Parameters:
- CLK_DIV, 1_000_000, system clocks per centisecond tick (100 MHz -> 100 Hz); must be >= 2.
- DIV_W, 20, width of divider counter; must hold CLK_DIV-1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-low reset (asserted when 0).
- run  in  1  1 = timekeeping advances; 0 = divider and counters hold.
- btn_hour  in  1  debounced, synchronous level; each rising edge increments hour.
- btn_min  in  1  debounced, synchronous level; each rising edge increments minute.
- btn_sec  in  1  debounced, synchronous level; each rising edge zeroes sec/msec/divider.
- mode_12h  in  1  1 = 12-hour display, 0 = 24-hour display.
- alarm_en  in  1  alarm enable.
- alarm_hour  in  5  alarm hour, 0-23, 24-hour form.
- alarm_min  in  6  alarm minute, 0-59.
- o_msec  out  7  centiseconds, 0-99.
- o_sec  out  6  seconds, 0-59.
- o_min  out  6  minutes, 0-59.
- o_hour  out  5  display hour: 0-23 in 24-hour mode, 1-12 in 12-hour mode.
- o_pm  out  1  1 when internal hour >= 12 and mode_12h=1; 0 otherwise.
- o_alarm  out  1  one-clock alarm pulse.

Behaviour:
- Reset (rst=0, async): divider, msec, sec, min, hour, o_alarm and button edge registers all go to 0. Outputs read 00:00:00.00, o_pm=0. In 12-hour mode o_hour reads 12, because display is combinational.
- Edge registers reset to 0, so a button held high at reset release counts as one press on the first clock.
- Divider: counts 0..CLK_DIV-1 while run=1, wraps to 0. tick=1 in the cycle the divider equals CLK_DIV-1 and run=1. With run=0 the divider holds its value (no restart on resume).
- Carry chain on tick, all updates in the same clock:
  - msec 99->0 carries to sec.
  - sec 59->0 carries to min.
  - min 59->0 carries to hour.
  - hour 23->0 (internal hour is always 24-hour form).
- Latency: first msec increment occurs CLK_DIV clocks after reset release with run=1.
- Button edge = level & ~previous level, registered one cycle. Adjustments apply regardless of run.
  - btn_hour: hour <= (hour+1) mod 24. No side effects.
  - btn_min: min <= (min+1) mod 60. No carry into hour.
  - btn_sec: sec, msec and divider <= 0 (synchronises seconds). A tick in the same cycle is discarded.
- Simultaneous events: a button edge on a field overrides any carry into that same field in that cycle; the carry is dropped. Lower fields roll normally. Multiple button edges in one cycle all apply independently.
- Display mapping (combinational from registers):
  - mode_12h=0: o_hour = hour, o_pm = 0.
  - mode_12h=1: hour 0 -> 12; hour 1-12 -> unchanged; hour 13-23 -> hour-12. o_pm = (hour >= 12).
  - Changing mode never alters internal counters.
- Alarm: o_alarm is registered. It is 1 for exactly one clock following a tick-driven min carry (sec 59->0 transition) that lands on hour==alarm_hour and min==alarm_min with alarm_en=1.
  - Button-driven changes never fire the alarm.
  - Out-of-range alarm values never match.
- Reset mid-operation: immediate clear of all state, including a pending o_alarm.

Test Plan:
- CLK_DIV=4, run=1 from reset release -> o_msec=1 after 4 clocks; o_msec=99 after 396 clocks; o_sec=1, o_msec=0 after 400 clocks.
- 23 btn_hour pulses plus 59 btn_min pulses, then btn_sec, run to 59.99 -> next tick gives 00:00:00.00 (hour wraps, no extra carry).
- run=0 for 50 clocks mid-count -> all outputs and divider frozen; resume -> next msec step completes the remaining divider count.
- Hour set to 0, 12, 13, 23 with mode_12h=1 -> o_hour/o_pm = 12/0, 12/1, 1/1, 11/1. Same hours with mode_12h=0 -> 0/0, 12/0, 13/0, 23/0.
- alarm_en=1, alarm 00:01 -> one-clock o_alarm at the 00:00:59.99->00:01:00.00 rollover. No pulse when the minute is reached by btn_min. No pulse with alarm_en=0.
- btn_min edge coincident with a sec 59->0 carry at min=10 -> min=11 (carry dropped). btn_sec coincident with tick -> sec=msec=divider=0. rst=0 asserted mid-count -> all outputs 0 asynchronously.
